mem_arbiter: RTL and testbench

Single-port memory arbiter between the CPU's instruction-fetch port and its data load/store port. It serialises both request streams onto one shared 16-bit synchronous SRAM, inserts a programmable number of wait states, and returns read data with a one-cycle completion pulse per port. It sits directly downstream of the CPU's address registers and memory read/write strobes, and upstream of the physical memory.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_wait_cnt.sv | 28 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  // Arbiter sequencing: wait for a request, drive the memory, report completion.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Which requester owns the transaction currently in flight.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Width of the wait-state counter; supports 0..15 extra memory cycles.
  localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Loadable down-counter with a zero flag, used to time the memory access window.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  // Load takes precedence; decrement saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter serialising the instruction-fetch and data ports onto one synchronous SRAM.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration instead of
// fixed data-over-instruction priority.
//
// Handshake: a port raises its request (i_req, or d_rd/d_wr) and holds it; the
// arbiter grants only from IDLE, runs WAIT_STATES+1 ACCESS cycles, then pulses the
// port's done for one cycle with read data valid in that cycle. Requests changing
// after the grant do not affect the in-flight access; a request still high when
// the arbiter is back in IDLE is taken as a fresh transaction.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output state_t            fsm_state
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_STATES[WAIT_W-1:0];

  state_t state_q;
  state_t state_d;
  grant_t gnt_q;
  logic   dir_q;
  logic   d_req;
  logic   any_req;
  logic   prefer_d;
  logic   pick_d;
  logic   start;
  logic   finish;
  logic   cnt_zero;

  // A simultaneous read and write on the data port is a write.
  assign d_req   = d_rd | d_wr;
  assign any_req = d_req | i_req;
  assign pick_d  = d_req && (!i_req || prefer_d);
  assign start   = (state_q == IDLE) && any_req;
  assign finish  = (state_q == ACCESS) && cnt_zero;

`ifdef MEM_ARB_RR_EN
  grant_t last_gnt;

  // Remember the last winner so a contended grant alternates; reset favours data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= GNT_I;
    end else if (start) begin
      last_gnt <= pick_d ? GNT_D : GNT_I;
    end
  end

  assign prefer_d = (last_gnt == GNT_I);
`else
  assign prefer_d = 1'b1;
`endif

  mem_arb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (start),
    .load_val (WAIT_LOAD),
    .dec      (state_q == ACCESS),
    .zero     (cnt_zero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one access per grant, one DONE cycle, back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_zero) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fsm_state = state_q;

  // Latch the winner's request at grant and drive the memory for the access window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_q     <= GNT_I;
      dir_q     <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      gnt_q    <= pick_d ? GNT_D : GNT_I;
      dir_q    <= pick_d && d_wr;
      mem_ce   <= 1'b1;
      mem_we   <= pick_d && d_wr;
      mem_addr <= pick_d ? d_addr : i_addr;
      if (pick_d && d_wr) mem_wdata <= d_wdata;
    end else if (finish) begin
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
    end
  end

  // Capture read data on the last access cycle and pulse the owner's done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      busy    <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      busy   <= (state_d != IDLE);
      if (finish) begin
        if (gnt_q == GNT_D) begin
          d_done <= 1'b1;
          if (!dir_q) d_rdata <= mem_rdata;
        end else begin
          i_done  <= 1'b1;
          i_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases, randomized traffic checked
// against a transaction-timeline reference model, and a zero-wait-state instance.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int WS = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (WAIT_STATES = 2) ----------------
  logic        i_req;
  logic [7:0]  i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        d_rd;
  logic        d_wr;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        mem_ce;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;
  state_t      fsm_state;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(WS)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_rd      (d_rd),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- second DUT (WAIT_STATES = 0), instruction port only ----------------
  logic        z_i_req;
  logic [7:0]  z_i_addr;
  logic [15:0] z_i_rdata;
  logic        z_i_done;
  logic [15:0] z_d_rdata;
  logic        z_d_done;
  logic        z_mem_ce;
  logic        z_mem_we;
  logic [7:0]  z_mem_addr;
  logic [15:0] z_mem_wdata;
  logic [15:0] z_mem_rdata;
  logic        z_busy;
  state_t      z_fsm_state;

  mem_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_STATES(0)) u_dut_ws0 (
    .clk       (clk),
    .reset     (reset),
    .i_req     (z_i_req),
    .i_addr    (z_i_addr),
    .i_rdata   (z_i_rdata),
    .i_done    (z_i_done),
    .d_rd      (1'b0),
    .d_wr      (1'b0),
    .d_addr    (8'h00),
    .d_wdata   (16'h0000),
    .d_rdata   (z_d_rdata),
    .d_done    (z_d_done),
    .mem_ce    (z_mem_ce),
    .mem_we    (z_mem_we),
    .mem_addr  (z_mem_addr),
    .mem_wdata (z_mem_wdata),
    .mem_rdata (z_mem_rdata),
    .busy      (z_busy),
    .fsm_state (z_fsm_state)
  );

  // ---------------- SRAM model (shared image, combinational read) ----------------
  logic [15:0] sram [0:255];
  assign mem_rdata   = sram[mem_addr];
  assign z_mem_rdata = sram[z_mem_addr];

  always @(posedge clk) begin
    if (mem_ce && mem_we) sram[mem_addr] <= mem_wdata;
  end

  // ---------------- reference model state / scoreboard ----------------
  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_i_rdata;
  logic [15:0] exp_d_rdata;
  bit          model_last_d;
  logic [15:0] exp_q[$];

  int n_total;
  int n_pass;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver + timeline model ----------------
  // Requests are presented at the current negedge and sampled at the next posedge.
  // Model: each granted transaction occupies WS+1 ACCESS cycles then one DONE cycle;
  // a second contending transaction is sampled in the IDLE cycle after that DONE.
  task automatic run_txn(input bit ir, input bit dr, input bit dw,
                         input logic [7:0] ia, input logic [7:0] da,
                         input logic [15:0] wd, input bit scramble);
    bit          pd[2];
    bit          wr[2];
    logic [7:0]  ad[2];
    logic [15:0] wv[2];
    int          js[2];
    int          jd[2];
    int          n;
    int          jend;
    bit          first_d;
    bit          e_ce, e_we, e_id, e_dd, e_busy;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;

    i_req = ir; i_addr = ia;
    d_rd = dr; d_wr = dw; d_addr = da; d_wdata = wd;

`ifdef MEM_ARB_RR_EN
    first_d = !model_last_d;
`else
    first_d = 1'b1;
`endif
    n = 0;
    if (ir && (dr || dw)) begin
      pd[0] = first_d; pd[1] = !first_d; n = 2;
    end else if (ir) begin
      pd[0] = 1'b0; n = 1;
    end else if (dr || dw) begin
      pd[0] = 1'b1; n = 1;
    end
    for (int k = 0; k < 2; k++) begin
      wr[k] = pd[k] && dw;
      ad[k] = pd[k] ? da : ia;
      wv[k] = wd;
    end
    if (n > 0) model_last_d = pd[n-1];
    js[0] = 1;      jd[0] = WS + 2;
    js[1] = WS + 4; jd[1] = 2 * WS + 5;
    jend = (n == 0) ? 1 : jd[n-1] + 1;

    for (int j = 1; j <= jend; j++) begin
      @(negedge clk);
      e_ce = 0; e_we = 0; e_id = 0; e_dd = 0; e_busy = 0;
      e_addr = '0; e_wdata = '0;
      for (int k = 0; k < n; k++) begin
        if (j >= js[k] && j <= js[k] + WS) begin
          e_ce = 1; e_we = wr[k]; e_addr = ad[k]; e_wdata = wv[k];
        end
        if (j >= js[k] && j <= jd[k]) e_busy = 1;
        if (j == jd[k]) begin
          if (pd[k]) begin
            e_dd = 1;
            if (wr[k]) ref_mem[ad[k]] = wv[k];
            else exp_d_rdata = ref_mem[ad[k]];
          end else begin
            e_id = 1;
            exp_i_rdata = ref_mem[ad[k]];
          end
        end
      end
      check("mem_ce", mem_ce, e_ce);
      check("mem_we", mem_we, e_we);
      if (e_ce) check("mem_addr", mem_addr, e_addr);
      if (e_we) check("mem_wdata", mem_wdata, e_wdata);
      check("i_done", i_done, e_id);
      check("d_done", d_done, e_dd);
      check("busy", busy, e_busy);
      check("i_rdata", i_rdata, exp_i_rdata);
      check("d_rdata", d_rdata, exp_d_rdata);

      // Requester behaviour: drop after done, optionally disturb inputs after grant.
      for (int k = 0; k < n; k++) begin
        if (j == jd[k]) begin
          if (pd[k]) begin d_rd = 0; d_wr = 0; end
          else i_req = 0;
        end
        if (scramble && j == js[k]) begin
          if (pd[k]) begin
            d_addr = 8'($urandom); d_wdata = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin d_rd = 0; d_wr = 0; end
          end else begin
            i_addr = 8'($urandom);
            if ($urandom_range(0, 3) == 0) i_req = 0;
          end
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          ir, dr, dw;
    logic [7:0]  ia, da;
    logic [15:0] wd;
    int          diffs;
    bit          z_id, z_ce;

    n_total = 0; n_pass = 0; n_fail = 0;
    model_last_d = 0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    reset = 1'b0;
    i_req = 0; i_addr = '0; d_rd = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    z_i_req = 0; z_i_addr = '0;
    for (int a = 0; a < 256; a++) begin
      sram[a] = 16'($urandom);
      ref_mem[a] = sram[a];
    end
    sram[8'h10] = 16'hA5C3;
    ref_mem[8'h10] = 16'hA5C3;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_i_rdata", i_rdata, 16'h0);
    check("rst_i_done", i_done, 1'b0);
    check("rst_d_rdata", d_rdata, 16'h0);
    check("rst_d_done", d_done, 1'b0);
    check("rst_mem_ce", mem_ce, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h0);
    check("rst_mem_wdata", mem_wdata, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    // Directed: instruction read, data write, contention, read+write, reset abort.
    run_txn(1, 0, 0, 8'h10, 8'h00, 16'h0000, 0);
    check("dir_i_rdata_a5c3", i_rdata, 16'hA5C3);
    run_txn(0, 0, 1, 8'h00, 8'h20, 16'h1234, 0);
    run_txn(1, 1, 0, 8'h30, 8'h20, 16'h0000, 0);
    check("dir_d_rdata_1234", d_rdata, 16'h1234);
    run_txn(0, 1, 1, 8'h00, 8'h21, 16'hBEEF, 0);
    check("dir_rw_keeps_rdata", d_rdata, 16'h1234);

    // Reset asserted mid-access: memory strobes drop at once, no done pulse.
    i_req = 1; i_addr = 8'h10;
    repeat (2) @(negedge clk);
    check("pre_rst_ce", mem_ce, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_ce", mem_ce, 1'b0);
    check("rst_mid_we", mem_we, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_i_done", i_done, 1'b0);
    exp_i_rdata = '0; exp_d_rdata = '0; model_last_d = 0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      check("rst_hold_i_done", i_done, 1'b0);
      check("rst_hold_ce", mem_ce, 1'b0);
    end
    reset = 1'b1;
    run_txn(1, 0, 0, 8'h10, 8'h00, 16'h0000, 0);
    check("post_rst_i_rdata", i_rdata, 16'hA5C3);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dw = ($urandom_range(0, 2) == 0);
      ia = 8'($urandom_range(0, 15));
      da = 8'($urandom_range(0, 15));
      wd = 16'($urandom);
      run_txn(ir, dr, dw, ia, da, wd, 1);
      if ($urandom_range(0, 2) == 0) run_txn(0, 0, 0, 8'h00, 8'h00, 16'h0000, 0);
    end

    // Zero wait states: back-to-back instruction reads at 0 and 1.
    exp_q.push_back(ref_mem[8'h00]);
    exp_q.push_back(ref_mem[8'h01]);
    z_i_req = 1; z_i_addr = 8'h00;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      z_ce = (j == 1 || j == 4);
      z_id = (j == 2 || j == 5);
      check("ws0_mem_ce", z_mem_ce, z_ce);
      check("ws0_i_done", z_i_done, z_id);
      if (z_ce) check("ws0_mem_addr", z_mem_addr, (j == 1) ? 8'h00 : 8'h01);
      if (z_id && exp_q.size() > 0) check("ws0_i_rdata", z_i_rdata, exp_q.pop_front());
      if (j == 2) z_i_addr = 8'h01;
      if (j == 5) z_i_req = 0;
    end
    check("ws0_d_done", z_d_done, 1'b0);

    // Final memory image against the reference.
    diffs = 0;
    for (int a = 0; a < 256; a++) if (sram[a] !== ref_mem[a]) diffs++;
    check("mem_image", diffs, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
